// File: rtl/pong_game_sequencer_pkg.sv
// Shared pong definitions: FSM state encoding, default game timing and score helpers.
package pong_game_sequencer_pkg;

  localparam int WIN_SCORE_DEF    = 9;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int POINT_FRAMES_DEF = 30;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  // Score increment that sticks at the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_sequencer_frame_tick_gen.sv
// vsync falling-edge detector; shared with the paddle logic as the per-frame tick.
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vsync_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_vsync_prev <= 1'b0;
    else       r_vsync_prev <= i_vsync;
  end

  assign o_tick = r_vsync_prev & ~i_vsync;

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong game sequencer: serve/play/point/game-over flow, scores and ball control strobes.
module pong_game_sequencer
  import pong_game_sequencer_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_vsync,
  input  logic       i_start,
  input  logic       i_miss_left,
  input  logic       i_miss_right,
  output logic       o_ball_enable,
  output logic       o_ball_reset,
  output logic       o_serve_dir,
  output logic [3:0] o_score_left,
  output logic [3:0] o_score_right,
  output logic [2:0] o_state,
  output logic       o_game_over,
  output logic       o_winner
);

  localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] LP_SERVE = 8'(SERVE_FRAMES);
  localparam logic [7:0] LP_POINT = 8'(POINT_FRAMES);

  logic       w_tick;
  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_score_left, r_score_right;
  logic       r_ball_enable, r_ball_reset, r_serve_dir, r_game_over, r_winner;

  frame_tick_gen u_frame_tick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vsync (i_vsync),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 8'd0;
      r_score_left  <= 4'd0;
      r_score_right <= 4'd0;
      r_serve_dir   <= 1'b1;
      r_ball_reset  <= 1'b0;
      r_ball_enable <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
    end else begin
      r_ball_reset <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAMEOVER: begin
          if (i_start) begin
            r_score_left  <= 4'd0;
            r_score_right <= 4'd0;
            r_serve_dir   <= 1'b1;
            r_cnt         <= LP_SERVE;
            r_ball_reset  <= 1'b1;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
            r_state       <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (w_tick) begin
            if (r_cnt == 8'd1) begin
              r_ball_enable <= 1'b1;
              r_state       <= ST_PLAY;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        ST_PLAY: begin
          if (i_miss_left | i_miss_right) begin
            r_ball_enable <= 1'b0;
            r_cnt         <= LP_POINT;
            r_state       <= ST_POINT;
            // A double miss is a void rally: nobody scores, serve side kept.
            if (i_miss_left & ~i_miss_right) begin
              r_score_right <= sat_inc(r_score_right, LP_WIN);
              r_serve_dir   <= 1'b0;
            end
            if (i_miss_right & ~i_miss_left) begin
              r_score_left <= sat_inc(r_score_left, LP_WIN);
              r_serve_dir  <= 1'b1;
            end
          end
        end
        ST_POINT: begin
          if (w_tick) begin
            if (r_cnt == 8'd1) begin
              if ((r_score_left == LP_WIN) || (r_score_right == LP_WIN)) begin
                r_game_over <= 1'b1;
                r_winner    <= (r_score_right == LP_WIN);
                r_state     <= ST_GAMEOVER;
              end else begin
                r_ball_reset <= 1'b1;
                r_cnt        <= LP_SERVE;
                r_state      <= ST_SERVE;
              end
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ball_enable = r_ball_enable;
  assign o_ball_reset  = r_ball_reset;
  assign o_serve_dir   = r_serve_dir;
  assign o_score_left  = r_score_left;
  assign o_score_right = r_score_right;
  assign o_state       = r_state;
  assign o_game_over   = r_game_over;
  assign o_winner      = r_winner;

endmodule

// File: doc/pong_game_sequencer.md
PONG_GAME_SEQUENCER -- requirements
Module: pong_game_sequencer

Interface
REQ-001 Parameter WIN_SCORE, default 9: points that end the game (1..15).
REQ-002 Parameter SERVE_FRAMES, default 60: frames the ball is held before each serve (1..255).
REQ-003 Parameter POINT_FRAMES, default 30: frames the ball is frozen after a point (1..255).
REQ-004 clk  input  1  single system/pixel clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 vsync  input  1  frame sync from the VGA timing generator; high during vertical sync.
REQ-007 start  input  1  one-cycle pulse (debounced button) that starts a new game.
REQ-008 miss_left  input  1  one-cycle pulse: ball left the field on the left side.
REQ-009 miss_right  input  1  one-cycle pulse: ball left the field on the right side.
REQ-010 ball_enable  output  1  ball controller may move the ball this frame.
REQ-011 ball_reset  output  1  one-cycle pulse: ball controller re-centres the ball.
REQ-012 serve_dir  output  1  initial x direction after ball_reset (1 = right, 0 = left).
REQ-013 score_left  output  4  left player score.
REQ-014 score_right  output  4  right player score.
REQ-015 state  output  3  current FSM state encoding (debug/display).
REQ-016 game_over  output  1  high while in GAMEOVER.
REQ-017 winner  output  1  valid when game_over is high (1 = right player, 0 = left player).

Function
REQ-018 frame_tick SHALL be a one-cycle internal pulse, asserted in the cycle after vsync is sampled falling (registered previous value 1, current value 0).
REQ-019 The FSM SHALL have states IDLE, SERVE, PLAY, POINT and GAMEOVER, plus an 8-bit frame down-counter.
REQ-020 IDLE: ball_enable = 0; on start -> clear both scores, set serve_dir = 1, load counter with SERVE_FRAMES, pulse ball_reset, go to SERVE.
REQ-021 SERVE: ball_enable = 0; each frame_tick decrements the counter; the tick at which the counter is 1 -> PLAY (exactly SERVE_FRAMES ticks spent in SERVE).
REQ-022 PLAY: ball_enable = 1; miss_left only -> score_right + 1, serve_dir = 0; miss_right only -> score_left + 1, serve_dir = 1; on either, load counter with POINT_FRAMES and go to POINT in the next cycle.
REQ-023 PLAY, miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT.
REQ-024 POINT: ball_enable = 0; counts POINT_FRAMES frame_ticks as in SERVE; on expiry, if either score equals WIN_SCORE -> GAMEOVER, else pulse ball_reset, load SERVE_FRAMES, go to SERVE.
REQ-025 GAMEOVER: game_over = 1, winner = (score_right == WIN_SCORE); scores held; on start -> same actions as start in IDLE.
REQ-026 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-027 miss_left/miss_right SHALL be ignored outside PLAY; start SHALL be ignored in SERVE, PLAY and POINT.
REQ-028 ball_reset SHALL be high for exactly one cycle per transition into SERVE and low at all other times.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst SHALL force state = IDLE, counter = 0, score_left = score_right = 0, serve_dir = 1, ball_reset = 0, ball_enable = 0, game_over = 0, winner = 0, and clear the vsync history register, including when rst is asserted mid-SERVE or mid-PLAY.
REQ-031 rst SHALL take priority over start and the miss inputs in the same cycle.

Structure
REQ-032 The state encoding localparams and the default WIN_SCORE/SERVE_FRAMES/POINT_FRAMES values SHALL live in the shared pong package/include file.
REQ-033 The vsync falling-edge detector SHALL be a separate sub-module named frame_tick_gen, reusable by the paddle logic.

Verification (bench parameters: WIN_SCORE = 3, SERVE_FRAMES = 2, POINT_FRAMES = 1)
REQ-034 rst then start -> one ball_reset pulse, state SERVE, scores 0/0; after 2 frame_ticks -> PLAY, ball_enable = 1.
REQ-035 In PLAY, miss_right -> score_left = 1, serve_dir = 1, POINT; after 1 tick -> ball_reset pulse, SERVE.
REQ-036 Three miss_left points -> score_right = 3, then GAMEOVER, game_over = 1, winner = 1; further misses leave score_right = 3.
REQ-037 Simultaneous miss_left and miss_right in PLAY -> scores unchanged, POINT entered; misses and start during SERVE/POINT have no effect.
REQ-038 rst asserted mid-PLAY with scores 2/1 -> next cycle IDLE, scores 0/0, ball_enable = 0; start in GAMEOVER -> new game with scores 0/0.
